// File: rtl/clock_multiplier.sv
// -----------------------------------------------------------------------------
// clock_multiplier
//
// Measures the period of a slow asynchronous reference (ref_in) in clk_in
// cycles and emits MULT evenly spaced single-cycle ticks per reference period.
// Tick 0 is phase-aligned to each reference rising edge.
//
// Parameters
//   MULT       ticks per reference period (>= 2, < 2**CNT_W)
//   CNT_W      width of period counter, accumulator base and period output
//   MAX_PERIOD longest accepted period; reaching it without an edge times out
//
// Ports
//   clk_in    in   system clock, all logic on its rising edge
//   reset     in   asynchronous active-high reset
//   ref_in    in   asynchronous reference, rising edges define periods
//   tick_out  out  single-cycle tick strobe, MULT per locked period
//   clk_out   out  toggles on every tick_out
//   period    out  last accepted period in clk_in cycles
//   locked    out  high while ticks track a valid period
//   timeout   out  one-cycle pulse when no edge arrives within MAX_PERIOD
// -----------------------------------------------------------------------------
module clock_multiplier #(
   parameter int MULT       = 4,
   parameter int CNT_W      = 16,
   parameter int MAX_PERIOD = (1 << CNT_W) - 1
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             ref_in,
   output logic             tick_out,
   output logic             clk_out,
   output logic [CNT_W-1:0] period,
   output logic             locked,
   output logic             timeout
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   localparam logic [CNT_W:0]   MULT_W  = (CNT_W+1)'(MULT);
   localparam logic [CNT_W:0]   MAX_W   = (CNT_W+1)'(MAX_PERIOD);
   localparam logic [CNT_W-1:0] MULT_T  = CNT_W'(MULT);
   localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(MAX_PERIOD - 1);

   state_t           state;
   logic             sync1, sync2, sync3;
   logic             rise;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W:0]   acc;
   logic [CNT_W-1:0] tcnt;

   logic [CNT_W:0]   p_meas;
   logic             p_valid;
   logic [CNT_W:0]   acc_sum;
   logic             tick_run;
   logic             tick_step;

   // Synchronizer, delay flop and registered edge strobe. Registering the
   // strobe puts 'rise' one cycle after the second sync stage.
   // NOTE: every flop here, including the synchronizer, is cleared by the
   // async reset so a reset mid-stream cannot leave a stale edge in flight.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
         rise  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so each stage samples the previous
         // stage's old value and the chain really is three flops deep.
         sync1 <= ref_in;
         sync2 <= sync1;
         sync3 <= sync2;
         rise  <= sync2 & ~sync3;
      end
   end

   // Period measurement and fractional tick step. acc < period <= MAX_PERIOD,
   // so one extra bit is enough for acc + MULT to never wrap.
   always_comb begin
      // NOTE: every output of this block gets a value on every path, so no
      // latch is inferred.
      p_meas    = {1'b0, cnt} + (CNT_W+1)'(1);
      p_valid   = (p_meas >= MULT_W) && (p_meas <= MAX_W);
      acc_sum   = acc + MULT_W;
      tick_run  = (state == LOCKED) && (tcnt < MULT_T);
      tick_step = tick_run && (acc_sum >= {1'b0, period});
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         tcnt     <= '0;
         period   <= '0;
         locked   <= 1'b0;
         timeout  <= 1'b0;
         tick_out <= 1'b0;
         clk_out  <= 1'b0;
      end else begin
         timeout  <= 1'b0;
         tick_out <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (rise) state <= MEASURE;
            end
            MEASURE, LOCKED: begin
               if (rise) begin
                  cnt <= '0;
                  if (p_valid) begin
                     // Accepted edge: latch period and re-phase with tick 0,
                     // dropping any ticks still owed from the last period.
                     period   <= p_meas[CNT_W-1:0];
                     state    <= LOCKED;
                     locked   <= 1'b1;
                     tick_out <= 1'b1;
                     clk_out  <= ~clk_out;
                     acc      <= '0;
                     tcnt     <= CNT_W'(1);
                  end else begin
                     // Too-short period (glitch): drop lock, keep old period.
                     state  <= MEASURE;
                     locked <= 1'b0;
                  end
               end else if (cnt == TO_CNT) begin
                  timeout <= 1'b1;
                  state   <= IDLE;
                  locked  <= 1'b0;
                  cnt     <= '0;
                  acc     <= '0;
                  tcnt    <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (tick_step) begin
                     tick_out <= 1'b1;
                     clk_out  <= ~clk_out;
                     acc      <= acc_sum - {1'b0, period};
                     tcnt     <= tcnt + CNT_W'(1);
                  end else if (tick_run) begin
                     acc <= acc_sum;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clock_multiplier.sv
// -----------------------------------------------------------------------------
// tb_clock_multiplier
//
// Directed bench for clock_multiplier with MULT=4, CNT_W=16, MAX_PERIOD=100.
// Reference edges are driven on the falling edge of clk_in. A rising ref_in
// driven at falling edge N0 yields tick 0 / period / locked after the fourth
// following rising edge, i.e. visible at the fourth falling edge after N0.
// Tick offsets below are measured from that point.
// -----------------------------------------------------------------------------
module tb_clock_multiplier;

   localparam int MULT  = 4;
   localparam int CNT_W = 16;
   localparam int MAX_P = 100;

   logic             clk_in = 1'b0;
   logic             reset  = 1'b1;
   logic             ref_in = 1'b0;
   logic             tick_out;
   logic             clk_out;
   logic [CNT_W-1:0] period;
   logic             locked;
   logic             timeout;

   int checks = 0;
   int errors = 0;

   // Results of the most recent send_period call
   int               n_ticks;
   int               offs[8];
   int               tog_err;
   logic             lk4;
   logic [CNT_W-1:0] per4;

   clock_multiplier #(
      .MULT       (MULT),
      .CNT_W      (CNT_W),
      .MAX_PERIOD (MAX_P)
   ) dut (
      .clk_in   (clk_in),
      .reset    (reset),
      .ref_in   (ref_in),
      .tick_out (tick_out),
      .clk_out  (clk_out),
      .period   (period),
      .locked   (locked),
      .timeout  (timeout)
   );

   always #5 clk_in = ~clk_in;

   // Drives one reference period of p cycles (high for 'high' cycles) starting
   // at the current falling edge. Records ticks at offset >= 0 from this
   // edge's tick-0 slot, clk_out/tick_out consistency, and locked/period at
   // the tick-0 slot.
   task automatic send_period(input int p, input int high);
      logic prev_clk;
      n_ticks = 0;
      tog_err = 0;
      lk4     = 1'b0;
      per4    = '0;
      for (int k = 0; k < 8; k++) offs[k] = -1;
      prev_clk = clk_out;
      ref_in   = 1'b1;
      for (int i = 1; i <= p; i++) begin
         @(negedge clk_in);
         if ((clk_out !== prev_clk) !== (tick_out === 1'b1)) tog_err++;
         prev_clk = clk_out;
         if (tick_out === 1'b1 && i >= 4) begin
            if (n_ticks < 8) offs[n_ticks] = i - 4;
            n_ticks++;
         end
         if (i == 4) begin
            lk4  = locked;
            per4 = period;
         end
         if (i == high) ref_in = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      ref_in = 1'b0;
      repeat (3) @(negedge clk_in);
      checks++; if (tick_out !== 1'b0) begin errors++; $display("FAIL reset_tick_out: got %b expected 0", tick_out); end
      checks++; if (clk_out  !== 1'b0) begin errors++; $display("FAIL reset_clk_out: got %b expected 0", clk_out); end
      checks++; if (period   !== '0)   begin errors++; $display("FAIL reset_period: got %0d expected 0", period); end
      checks++; if (locked   !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
      checks++; if (timeout  !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
      reset = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_lock();
      int exp[4] = '{0, 8, 15, 23};
      send_period(30, 15);
      checks++; if (n_ticks != 0) begin errors++; $display("FAIL lock_first_edge_ticks: got %0d expected 0", n_ticks); end
      checks++; if (lk4 !== 1'b0) begin errors++; $display("FAIL lock_first_edge_locked: got %b expected 0", lk4); end
      for (int rep = 0; rep < 2; rep++) begin
         send_period(30, 15);
         checks++; if (lk4 !== 1'b1) begin errors++; $display("FAIL lock_locked[%0d]: got %b expected 1", rep, lk4); end
         checks++; if (per4 !== 16'd30) begin errors++; $display("FAIL lock_period[%0d]: got %0d expected 30", rep, per4); end
         checks++; if (n_ticks != 4) begin errors++; $display("FAIL lock_tick_count[%0d]: got %0d expected 4", rep, n_ticks); end
         checks++; if (tog_err != 0) begin errors++; $display("FAIL lock_clk_out_toggle[%0d]: got %0d bad cycles expected 0", rep, tog_err); end
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (offs[k] != exp[k]) begin errors++; $display("FAIL lock_tick_offset[%0d][%0d]: got %0d expected %0d", rep, k, offs[k], exp[k]); end
         end
      end
   endtask

   task automatic test_period_change();
      int exp_a[4] = '{0, 8, 15, 23};
      int exp_b[4] = '{0, 10, 20, 30};
      // First 40-cycle window still starts from a 30-cycle measurement
      send_period(40, 20);
      checks++; if (per4 !== 16'd30) begin errors++; $display("FAIL chg_period_first: got %0d expected 30", per4); end
      checks++; if (n_ticks != 4) begin errors++; $display("FAIL chg_count_first: got %0d expected 4", n_ticks); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (offs[k] != exp_a[k]) begin errors++; $display("FAIL chg_offset_first[%0d]: got %0d expected %0d", k, offs[k], exp_a[k]); end
      end
      send_period(40, 20);
      checks++; if (per4 !== 16'd40) begin errors++; $display("FAIL chg_period: got %0d expected 40", per4); end
      checks++; if (lk4 !== 1'b1) begin errors++; $display("FAIL chg_locked: got %b expected 1", lk4); end
      checks++; if (n_ticks != 4) begin errors++; $display("FAIL chg_count: got %0d expected 4", n_ticks); end
      checks++; if (tog_err != 0) begin errors++; $display("FAIL chg_clk_out_toggle: got %0d bad cycles expected 0", tog_err); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (offs[k] != exp_b[k]) begin errors++; $display("FAIL chg_offset[%0d]: got %0d expected %0d", k, offs[k], exp_b[k]); end
      end
   endtask

   task automatic test_glitch();
      int exp[4] = '{0, 8, 15, 23};
      send_period(2, 1);   // valid edge (P=40) followed 2 cycles later by a glitch
      send_period(30, 15); // this window's edge measures P=2
      checks++; if (lk4 !== 1'b0) begin errors++; $display("FAIL glitch_locked: got %b expected 0", lk4); end
      checks++; if (per4 !== 16'd40) begin errors++; $display("FAIL glitch_period: got %0d expected 40", per4); end
      checks++; if (n_ticks != 0) begin errors++; $display("FAIL glitch_ticks: got %0d expected 0", n_ticks); end
      for (int rep = 0; rep < 2; rep++) begin
         send_period(30, 15);
         checks++; if (lk4 !== 1'b1) begin errors++; $display("FAIL relock_locked[%0d]: got %b expected 1", rep, lk4); end
         checks++; if (per4 !== 16'd30) begin errors++; $display("FAIL relock_period[%0d]: got %0d expected 30", rep, per4); end
         checks++; if (n_ticks != 4) begin errors++; $display("FAIL relock_count[%0d]: got %0d expected 4", rep, n_ticks); end
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (offs[k] != exp[k]) begin errors++; $display("FAIL relock_offset[%0d][%0d]: got %0d expected %0d", rep, k, offs[k], exp[k]); end
         end
      end
   endtask

   task automatic test_early_edge();
      int exp_a[3] = '{0, 8, 15};
      int exp_b[4] = '{0, 5, 10, 15};
      send_period(20, 10); // runs on period 30, cut short by the early edge
      checks++; if (n_ticks != 3) begin errors++; $display("FAIL early_cut_count: got %0d expected 3", n_ticks); end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (offs[k] != exp_a[k]) begin errors++; $display("FAIL early_cut_offset[%0d]: got %0d expected %0d", k, offs[k], exp_a[k]); end
      end
      send_period(30, 15); // edge measures P=20 and re-phases
      checks++; if (per4 !== 16'd20) begin errors++; $display("FAIL early_period: got %0d expected 20", per4); end
      checks++; if (lk4 !== 1'b1) begin errors++; $display("FAIL early_locked: got %b expected 1", lk4); end
      checks++; if (n_ticks != 4) begin errors++; $display("FAIL early_count: got %0d expected 4", n_ticks); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (offs[k] != exp_b[k]) begin errors++; $display("FAIL early_offset[%0d]: got %0d expected %0d", k, offs[k], exp_b[k]); end
      end
   endtask

   task automatic test_timeout();
      int to_cnt      = 0;
      int to_first    = 0;
      int ticks_after = 0;
      int n_pre       = 0;
      logic lk_pre    = 1'b0;
      logic lk_post   = 1'b1;
      ref_in = 1'b1;
      for (int i = 1; i <= 130; i++) begin
         @(negedge clk_in);
         if (i == 15) ref_in = 1'b0;
         if (i == 4) lk_pre = locked;
         if (tick_out === 1'b1 && i < 30) n_pre++;
         if (timeout === 1'b1) begin
            to_cnt++;
            if (to_first == 0) to_first = i;
         end
         if (to_first != 0 && tick_out === 1'b1) ticks_after++;
         if (i == 110) lk_post = locked;
      end
      checks++; if (lk_pre !== 1'b1) begin errors++; $display("FAIL to_locked_before: got %b expected 1", lk_pre); end
      checks++; if (n_pre != 4) begin errors++; $display("FAIL to_ticks_before: got %0d expected 4", n_pre); end
      checks++; if (to_cnt != 1) begin errors++; $display("FAIL to_pulse_count: got %0d expected 1", to_cnt); end
      checks++; if (to_first != 104) begin errors++; $display("FAIL to_pulse_time: got %0d expected 104", to_first); end
      checks++; if (lk_post !== 1'b0) begin errors++; $display("FAIL to_locked_after: got %b expected 0", lk_post); end
      checks++; if (ticks_after != 0) begin errors++; $display("FAIL to_ticks_after: got %0d expected 0", ticks_after); end
      // Back in IDLE: the next edge only starts a measurement
      send_period(30, 15);
      checks++; if (n_ticks != 0) begin errors++; $display("FAIL to_idle_ticks: got %0d expected 0", n_ticks); end
      checks++; if (lk4 !== 1'b0) begin errors++; $display("FAIL to_idle_locked: got %b expected 0", lk4); end
   endtask

   task automatic test_reset_mid();
      send_period(30, 15);
      checks++; if (lk4 !== 1'b1) begin errors++; $display("FAIL rmid_locked_before: got %b expected 1", lk4); end
      ref_in = 1'b1;
      repeat (10) @(negedge clk_in);
      #2;
      reset  = 1'b1;
      ref_in = 1'b0;
      #1; // still in the low phase of clk_in: only the async path can clear
      checks++; if (locked  !== 1'b0) begin errors++; $display("FAIL rmid_locked: got %b expected 0", locked); end
      checks++; if (period  !== '0)   begin errors++; $display("FAIL rmid_period: got %0d expected 0", period); end
      checks++; if (tick_out !== 1'b0) begin errors++; $display("FAIL rmid_tick_out: got %b expected 0", tick_out); end
      checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL rmid_clk_out: got %b expected 0", clk_out); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rmid_timeout: got %b expected 0", timeout); end
      repeat (3) @(negedge clk_in);
      reset = 1'b0;
      @(negedge clk_in);
      send_period(30, 15);
      checks++; if (n_ticks != 0) begin errors++; $display("FAIL rmid_first_ticks: got %0d expected 0", n_ticks); end
      checks++; if (lk4 !== 1'b0) begin errors++; $display("FAIL rmid_first_locked: got %b expected 0", lk4); end
      send_period(30, 15);
      checks++; if (lk4 !== 1'b1) begin errors++; $display("FAIL rmid_relock: got %b expected 1", lk4); end
      checks++; if (per4 !== 16'd30) begin errors++; $display("FAIL rmid_period_relock: got %0d expected 30", per4); end
      checks++; if (n_ticks != 4) begin errors++; $display("FAIL rmid_count_relock: got %0d expected 4", n_ticks); end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_period_change();
      test_glitch();
      test_early_edge();
      test_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/clock_multiplier.md
# clock_multiplier

Digital clock multiplier, the counterpart of the team's tick-based clock divider. It measures the period of a slow asynchronous reference, such as a divided clock or an encoder/PWM edge stream, in `clk_in` cycles. It then emits `MULT` evenly spaced single-cycle ticks per reference period, phase-aligned to each reference rising edge. Motor-control and sampling logic uses it to derive a fast strobe that tracks a slow external rate.

## Interface
- `MULT`, default 4: ticks per reference period. Must be ≥2 and < 2^CNT_W.
- `CNT_W`, default 16: width of the period counter, accumulator and `period` output.
- `MAX_PERIOD`, default 2^CNT_W−1: longest accepted period in clk_in cycles. Reaching it means timeout.
- `clk_in`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `ref_in`  input  1  asynchronous reference; rising edges define periods.
- `tick_out`  output  1  single-cycle tick strobe, `MULT` per locked period.
- `clk_out`  output  1  toggles on every `tick_out`.
- `period`  output  CNT_W  last accepted period in clk_in cycles.
- `locked`  output  1  high while the tick output tracks a valid period.
- `timeout`  output  1  one-cycle pulse when no reference edge arrives within `MAX_PERIOD`.

## Operation
- Synchronizer and edge detect:
  - `ref_in` passes through a 2-FF synchronizer plus a delay flop.
  - `rise` = sync2 & ~sync3, one cycle per reference rising edge.
- Period counter `cnt`:
  - On `rise`: cnt←0.
  - Otherwise: cnt←cnt+1.
  - Measured value at `rise` is P = cnt+1.
- State machine, states IDLE, MEASURE, LOCKED:
  - IDLE: on `rise`, go to MEASURE and set cnt←0.
  - MEASURE: on `rise` with MULT ≤ P ≤ MAX_PERIOD, set period←P and go to LOCKED. This is also tick 0.
  - MEASURE: on `rise` with P < MULT, stay in MEASURE and leave `period` unchanged.
  - LOCKED: on `rise` with valid P, set period←P, stay in LOCKED and emit tick 0.
  - LOCKED: on `rise` with P < MULT, go to MEASURE, clear `locked`, emit no tick.
  - MEASURE or LOCKED: if cnt reaches MAX_PERIOD−1 with no `rise`, pulse `timeout` for one cycle and go to IDLE.
- `locked` = (state == LOCKED), registered.
- Tick generator (fractional accumulator `acc`, CNT_W+1 bits, and tick counter `tcnt`):
  - On a tick-0 `rise`: tick_out←1, acc←0, tcnt←1.
  - Else, in LOCKED with tcnt < MULT: s = acc + MULT.
    - If s ≥ period: tick_out←1, acc←s−period, tcnt←tcnt+1.
    - Else: acc←s.
  - Else: tick_out←0, so at most `MULT` ticks per period.
  - A `rise` that arrives before tcnt reaches MULT re-phases anyway (acc←0, tick 0). Remaining ticks are dropped.
  - The arithmetic never wraps: acc < period ≤ MAX_PERIOD.
- `clk_out` toggles whenever `tick_out` is asserted.

## Timing
- Reset values: all outputs 0 (tick_out, clk_out, period, locked, timeout). Internally state=IDLE, cnt=acc=tcnt=0, sync flops 0.
- Latency from ref_in rising:
  - A ref_in rising edge meeting setup before clk_in edge E0 produces `rise` after edge E2.
  - tick_out, period and locked update on edge E3.
- First lock needs two reference rising edges. `locked` rises at the same edge as the first tick.
- Tick k (k = 0…MULT−1) lands ceil(k·P/MULT) cycles after tick 0 when the period is stable.
- Reset asserted mid-operation clears everything immediately. The first post-reset edge only enters MEASURE.

## Test plan
- Reset, then ref_in square wave with period 30 cycles and MULT=4:
  - No tick on the first edge.
  - Second edge gives locked=1 and period=30.
  - Ticks at offsets 0, 8, 15, 23 from each edge, exactly 4 per period.
  - clk_out toggles at each tick.
- Period changes 30→40 while locked: the next edge reports period=40, then ticks at offsets 0, 10, 20, 30. locked stays 1.
- ref_in held low after lock with MAX_PERIOD=100: timeout pulses once, 100 cycles after the last `rise`. Then locked=0, ticks stop, state is IDLE.
- Glitch edge giving P=2 (< MULT=4) while locked: locked→0, no tick, `period` unchanged. Two following valid edges (P=30) relock.
- Early edge at P=20 after a 30-cycle period: it re-phases (tick 0 at the edge) and period=20. Never more than 4 ticks between consecutive edges.
- Assert reset mid-period while locked: all outputs 0 asynchronously. After release, the first edge produces no tick and the second relocks.
